// File: rtl/udp_hdr_insert.sv
// ============================================================================
// udp_hdr_insert
//
// Sits between the UDP TX top level and the IP TX encapsulation stage.
// A UDP frame (8-byte UDP header followed by payload) arrives byte by byte
// before its final length and checksum are known. This block stores the
// whole frame in an on-chip RAM. It then waits for the late length/checksum
// handshake and replays the frame with UDP bytes 4..7 replaced by those
// final values.
//
// Only one frame is held at a time. The input stream is back-pressured while
// a frame waits for its header or is being replayed.
//
// Parameters
//   AXI_DATA_WIDTH : stream width in bits (only 8 is supported)
//   MAX_FRAME      : largest frame that can be buffered, in bytes
//   ADDR_WIDTH     : buffer address / byte counter width (derived)
//
// Ports
//   i_clk, i_reset          : clock, asynchronous active-high reset
//   s_tx_axis_*             : incoming frame bytes (tdata/tvalid/tlast/trdy)
//   s_udp_hdr_tvalid/trdy   : handshake for the final length and checksum
//   s_udp_length            : UDP length (header + payload) to insert
//   s_udp_checksum          : UDP checksum to insert (already complemented)
//   m_tx_axis_*             : outgoing frame bytes (tdata/tvalid/tlast/trdy)
//   o_drop                  : one-cycle pulse, frame discarded
//                             (runt or overflow)
//   o_len_err               : one-cycle pulse, s_udp_length differs from the
//                             number of bytes stored
// ============================================================================
module udp_hdr_insert #(
    parameter int AXI_DATA_WIDTH = 8,
    parameter int MAX_FRAME      = 1480,
    parameter int ADDR_WIDTH     = $clog2(MAX_FRAME + 1)
) (
    input  logic                      i_clk,
    input  logic                      i_reset,

    input  logic [AXI_DATA_WIDTH-1:0] s_tx_axis_tdata,
    input  logic                      s_tx_axis_tvalid,
    input  logic                      s_tx_axis_tlast,
    output logic                      s_tx_axis_trdy,

    input  logic                      s_udp_hdr_tvalid,
    output logic                      s_udp_hdr_trdy,
    input  logic [15:0]               s_udp_length,
    input  logic [15:0]               s_udp_checksum,

    output logic [AXI_DATA_WIDTH-1:0] m_tx_axis_tdata,
    output logic                      m_tx_axis_tvalid,
    output logic                      m_tx_axis_tlast,
    input  logic                      m_tx_axis_trdy,

    output logic                      o_drop,
    output logic                      o_len_err
);

    typedef enum logic [1:0] {
        STORE,
        WAIT_HDR,
        REPLAY
    } state_t;

    // The write counter stops at CNT_OVF. Reaching that value is how an
    // oversized frame is remembered until its header arrives.
    localparam logic [ADDR_WIDTH-1:0] CNT_ONE  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] CNT_MIN  = ADDR_WIDTH'(8);
    localparam logic [ADDR_WIDTH-1:0] CNT_FULL = ADDR_WIDTH'(MAX_FRAME);
    localparam logic [ADDR_WIDTH-1:0] CNT_OVF  = ADDR_WIDTH'(MAX_FRAME + 1);

    state_t                    state;
    state_t                    state_next;

    logic [AXI_DATA_WIDTH-1:0] mem [0:MAX_FRAME-1];
    logic [AXI_DATA_WIDTH-1:0] ram_q;

    logic [ADDR_WIDTH-1:0]     wr_cnt;
    logic [ADDR_WIDTH-1:0]     rd_ptr;
    logic [ADDR_WIDTH-1:0]     q_idx;
    logic [ADDR_WIDTH-1:0]     last_idx;
    logic                      q_valid;

    logic [15:0]               hdr_len;
    logic [15:0]               hdr_cks;

    logic                      wr_hs;
    logic                      hdr_hs;
    logic                      frame_bad;
    logic                      out_ready;
    logic                      out_done;
    logic                      rd_en;
    logic [AXI_DATA_WIDTH-1:0] sub_data;

    assign wr_hs     = s_tx_axis_tvalid & s_tx_axis_trdy;
    assign hdr_hs    = s_udp_hdr_tvalid & s_udp_hdr_trdy;
    assign frame_bad = (wr_cnt == CNT_OVF) || (wr_cnt < CNT_MIN);
    assign out_ready = ~m_tx_axis_tvalid | m_tx_axis_trdy;
    assign out_done  = m_tx_axis_tvalid & m_tx_axis_trdy & m_tx_axis_tlast;
    assign last_idx  = wr_cnt - CNT_ONE;

    // State register. An asynchronous reset always returns to STORE, so a
    // frame that was partly stored or partly replayed is simply forgotten.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state <= STORE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    // A frame ends its store phase on the tlast beat. It leaves WAIT_HDR on
    // the header handshake, and goes back to STORE at once when it is
    // unusable. Replay ends on the tlast handshake at the output.
    always_comb begin
        state_next = state;
        case (state)
            STORE: begin
                if (wr_hs && s_tx_axis_tlast) begin
                    state_next = WAIT_HDR;
                end
            end
            WAIT_HDR: begin
                if (hdr_hs) begin
                    state_next = frame_bad ? STORE : REPLAY;
                end
            end
            REPLAY: begin
                if (out_done) begin
                    state_next = STORE;
                end
            end
            default: state_next = STORE;
        endcase
    end

    // Output and control decode.
    // The first RAM read is issued in the same cycle as the header
    // handshake, so byte 0 reaches the output register two cycles after
    // that handshake. During replay a new read is issued only when the
    // prefetch slot (ram_q) will be empty at the next edge. That keeps
    // ram_q from being overwritten while the output is stalled.
    always_comb begin
        s_tx_axis_trdy = 1'b0;
        s_udp_hdr_trdy = 1'b0;
        o_drop         = 1'b0;
        o_len_err      = 1'b0;
        rd_en          = 1'b0;
        case (state)
            STORE: begin
                s_tx_axis_trdy = 1'b1;
            end
            WAIT_HDR: begin
                s_udp_hdr_trdy = 1'b1;
                if (s_udp_hdr_tvalid) begin
                    o_drop    = frame_bad;
                    o_len_err = (s_udp_length != 16'(wr_cnt));
                    rd_en     = ~frame_bad;
                end
            end
            REPLAY: begin
                rd_en = (rd_ptr < wr_cnt) && (~q_valid || out_ready);
            end
            default: ;
        endcase
    end

    // Frame buffer: one write port and one registered read port. It has no
    // reset so that it maps onto block RAM. Bytes past MAX_FRAME are not
    // written; the counter still records that they arrived.
    always_ff @(posedge i_clk) begin
        if (wr_hs && (wr_cnt < CNT_FULL)) begin
            mem[wr_cnt] <= s_tx_axis_tdata;
        end
        if (rd_en) begin
            ram_q <= mem[rd_ptr];
        end
    end

    // Byte substitution for the word in the prefetch slot.
    // Indices 4..7 carry the final length and checksum, high byte first.
    // All other indices pass the stored byte through unchanged.
    always_comb begin
        sub_data = ram_q;
        if ((q_idx[ADDR_WIDTH-1:3] == '0) && q_idx[2]) begin
            case (q_idx[1:0])
                2'd0: sub_data = hdr_len[15:8];
                2'd1: sub_data = hdr_len[7:0];
                2'd2: sub_data = hdr_cks[15:8];
                2'd3: sub_data = hdr_cks[7:0];
            endcase
        end
    end

    // Datapath registers: byte counters, the latched header, the prefetch
    // slot bookkeeping and the registered AXI output.
    // The output register loads whenever it is empty or being accepted.
    // This gives one byte per cycle while the consumer stays ready. It also
    // holds tdata/tlast steady under back-pressure. A checksum of zero is
    // sent as all ones, because zero on the wire means "no checksum".
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            wr_cnt           <= '0;
            rd_ptr           <= '0;
            q_idx            <= '0;
            q_valid          <= 1'b0;
            hdr_len          <= '0;
            hdr_cks          <= '0;
            m_tx_axis_tdata  <= '0;
            m_tx_axis_tvalid <= 1'b0;
            m_tx_axis_tlast  <= 1'b0;
        end else begin
            if (wr_hs && (wr_cnt != CNT_OVF)) begin
                wr_cnt <= wr_cnt + CNT_ONE;
            end

            if (hdr_hs) begin
                hdr_len <= s_udp_length;
                hdr_cks <= (s_udp_checksum == 16'h0000) ? 16'hFFFF : s_udp_checksum;
                if (frame_bad) begin
                    wr_cnt <= '0;
                end
            end

            if (rd_en) begin
                rd_ptr <= rd_ptr + CNT_ONE;
                q_idx  <= rd_ptr;
            end
            q_valid <= rd_en | (q_valid & ~out_ready);

            if (out_ready) begin
                m_tx_axis_tvalid <= q_valid;
                if (q_valid) begin
                    m_tx_axis_tdata <= sub_data;
                    m_tx_axis_tlast <= (q_idx == last_idx);
                end
            end

            if (out_done) begin
                wr_cnt <= '0;
                rd_ptr <= '0;
            end
        end
    end

endmodule

// File: tb/tb_udp_hdr_insert.sv
// ============================================================================
// tb_udp_hdr_insert
//
// Drives whole frames into udp_hdr_insert, hands over the final length and
// checksum, and collects the replayed frame under random downstream
// back-pressure. The expected frame is built from the original bytes: the
// frame is dropped when it is shorter than 8 bytes or longer than MAX_FRAME.
// Otherwise bytes 4..7 become length/checksum, and a zero checksum is sent
// as FFFF.
// ============================================================================
module tb_udp_hdr_insert;

    localparam int MAX_FRAME = 1480;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic [7:0]  s_tx_axis_tdata;
    logic        s_tx_axis_tvalid;
    logic        s_tx_axis_tlast;
    logic        s_tx_axis_trdy;
    logic        s_udp_hdr_tvalid;
    logic        s_udp_hdr_trdy;
    logic [15:0] s_udp_length;
    logic [15:0] s_udp_checksum;
    logic [7:0]  m_tx_axis_tdata;
    logic        m_tx_axis_tvalid;
    logic        m_tx_axis_tlast;
    logic        m_tx_axis_trdy;
    logic        o_drop;
    logic        o_len_err;

    int          checks    = 0;
    int          failures  = 0;
    int          drop_seen = 0;
    int          lerr_seen = 0;

    logic [7:0]  stim_q[$];
    logic [7:0]  exp_q[$];

    udp_hdr_insert #(
        .AXI_DATA_WIDTH (8),
        .MAX_FRAME      (MAX_FRAME)
    ) dut (
        .i_clk            (i_clk),
        .i_reset          (i_reset),
        .s_tx_axis_tdata  (s_tx_axis_tdata),
        .s_tx_axis_tvalid (s_tx_axis_tvalid),
        .s_tx_axis_tlast  (s_tx_axis_tlast),
        .s_tx_axis_trdy   (s_tx_axis_trdy),
        .s_udp_hdr_tvalid (s_udp_hdr_tvalid),
        .s_udp_hdr_trdy   (s_udp_hdr_trdy),
        .s_udp_length     (s_udp_length),
        .s_udp_checksum   (s_udp_checksum),
        .m_tx_axis_tdata  (m_tx_axis_tdata),
        .m_tx_axis_tvalid (m_tx_axis_tvalid),
        .m_tx_axis_tlast  (m_tx_axis_tlast),
        .m_tx_axis_trdy   (m_tx_axis_trdy),
        .o_drop           (o_drop),
        .o_len_err        (o_len_err)
    );

    // Free-running clock, period 10.
    always #5 i_clk = ~i_clk;

    // Pulse counters for the two status outputs, sampled mid-cycle.
    always @(negedge i_clk) begin
        if (o_drop)    drop_seen = drop_seen + 1;
        if (o_len_err) lerr_seen = lerr_seen + 1;
    end

    // Safety net so the run can never hang.
    initial begin
        #800000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point: counts the check and reports a mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks = checks + 1;
        if (observed !== expected) begin
            failures = failures + 1;
            $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Sends stim_q as one frame, hands over the header, and checks the
    // replay against the model. stop_after >= 0 returns mid-replay, at a
    // negedge, while output byte index stop_after is presented but not yet
    // accepted.
    task automatic applyStimulus(input logic [15:0] hlen, input logic [15:0] hcks,
                                 input int trdy_pct, input int idle_pct,
                                 input int stop_after, input string tag);
        int         n;
        int         eff;
        int         guard;
        int         cyc;
        int         got;
        int         first_valid;
        int         last_cyc;
        int         drop0;
        int         lerr0;
        int         stray;
        int         stable_err;
        int         last_err;
        bit         hs;
        bit         exp_drop;
        bit         exp_lerr;
        bit         prev_stall;
        logic       d_now;
        logic       l_now;
        logic [7:0] prev_data;
        logic       prev_last;
        logic [15:0] cks_final;

        n         = stim_q.size();
        eff       = (n > MAX_FRAME) ? MAX_FRAME + 1 : n;
        exp_drop  = (n > MAX_FRAME) || (n < 8);
        exp_lerr  = (hlen != 16'(eff));
        cks_final = (hcks == 16'h0000) ? 16'hFFFF : hcks;
        exp_q     = {};
        if (!exp_drop) begin
            foreach (stim_q[i]) exp_q.push_back(stim_q[i]);
            exp_q[4] = hlen[15:8];
            exp_q[5] = hlen[7:0];
            exp_q[6] = cks_final[15:8];
            exp_q[7] = cks_final[7:0];
        end
        drop0 = drop_seen;
        lerr0 = lerr_seen;

        // Byte input phase, with random idles and stray header requests.
        stray = 0;
        for (int i = 0; i < n; i++) begin
            while (int'($urandom_range(99)) < idle_pct) begin
                s_tx_axis_tvalid = 1'b0;
                s_udp_hdr_tvalid = 1'($urandom_range(1));
                @(negedge i_clk);
                if (m_tx_axis_tvalid || s_udp_hdr_trdy) stray++;
                @(posedge i_clk); #1;
            end
            s_tx_axis_tvalid = 1'b1;
            s_tx_axis_tdata  = stim_q[i];
            s_tx_axis_tlast  = (i == n - 1);
            s_udp_hdr_tvalid = 1'($urandom_range(1));
            s_udp_length     = 16'($urandom);
            s_udp_checksum   = 16'($urandom);
            hs = 1'b0;
            for (guard = 0; guard < 50 && !hs; guard++) begin
                @(negedge i_clk);
                hs = s_tx_axis_trdy;
                if (m_tx_axis_tvalid || s_udp_hdr_trdy) stray++;
                @(posedge i_clk); #1;
            end
            if (!hs) begin
                checkOutput($sformatf("%s_in_timeout", tag), 32'(hs), 32'd1);
                break;
            end
        end
        s_tx_axis_tvalid = 1'b0;
        s_tx_axis_tlast  = 1'b0;
        checkOutput($sformatf("%s_store_quiet", tag), 32'(stray), 32'd0);

        // Header handshake.
        s_udp_length     = hlen;
        s_udp_checksum   = hcks;
        s_udp_hdr_tvalid = 1'b1;
        hs    = 1'b0;
        d_now = 1'b0;
        l_now = 1'b0;
        for (guard = 0; guard < 50 && !hs; guard++) begin
            @(negedge i_clk);
            hs    = s_udp_hdr_trdy;
            d_now = o_drop;
            l_now = o_len_err;
            @(posedge i_clk); #1;
        end
        s_udp_hdr_tvalid = 1'b0;
        checkOutput($sformatf("%s_hdr_hs", tag), 32'(hs), 32'd1);
        if (!hs) return;
        checkOutput($sformatf("%s_drop_now", tag), 32'(d_now), 32'(exp_drop));
        checkOutput($sformatf("%s_lerr_now", tag), 32'(l_now), 32'(exp_lerr));

        if (exp_drop) begin
            stray = 0;
            repeat (20) begin
                m_tx_axis_trdy = 1'($urandom_range(1));
                @(negedge i_clk);
                if (m_tx_axis_tvalid) stray++;
                @(posedge i_clk); #1;
            end
            checkOutput($sformatf("%s_drop_silent", tag), 32'(stray), 32'd0);
            checkOutput($sformatf("%s_drop_pulses", tag), 32'(drop_seen - drop0), 32'd1);
            checkOutput($sformatf("%s_lerr_pulses", tag), 32'(lerr_seen - lerr0), 32'(exp_lerr));
            checkOutput($sformatf("%s_rdy_after", tag), 32'(s_tx_axis_trdy), 32'd1);
            return;
        end

        // Replay collection under random back-pressure.
        cyc = 0; got = 0; first_valid = -1; last_cyc = 0;
        stray = 0; stable_err = 0; last_err = 0;
        prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0;
        while (got < n && cyc < n * 30 + 100) begin
            m_tx_axis_trdy = (int'($urandom_range(99)) < trdy_pct);
            @(negedge i_clk);
            cyc++;
            if (stop_after >= 0 && got == stop_after) return;
            if (s_tx_axis_trdy) stray++;
            if (prev_stall && (!m_tx_axis_tvalid || m_tx_axis_tdata !== prev_data ||
                               m_tx_axis_tlast !== prev_last)) stable_err++;
            if (m_tx_axis_tvalid) begin
                if (first_valid < 0) first_valid = cyc;
                if (m_tx_axis_trdy) begin
                    checkOutput($sformatf("%s_byte%0d", tag, got),
                                32'(m_tx_axis_tdata), 32'(exp_q[got]));
                    if (m_tx_axis_tlast !== (got == n - 1)) last_err++;
                    got++;
                    last_cyc = cyc;
                end
            end
            prev_stall = m_tx_axis_tvalid && !m_tx_axis_trdy;
            prev_data  = m_tx_axis_tdata;
            prev_last  = m_tx_axis_tlast;
            @(posedge i_clk); #1;
        end
        checkOutput($sformatf("%s_count", tag), 32'(got), 32'(n));
        checkOutput($sformatf("%s_first_valid", tag), 32'(first_valid), 32'd2);
        checkOutput($sformatf("%s_stable", tag), 32'(stable_err), 32'd0);
        checkOutput($sformatf("%s_tlast", tag), 32'(last_err), 32'd0);
        checkOutput($sformatf("%s_in_blocked", tag), 32'(stray), 32'd0);
        if (trdy_pct >= 100) begin
            checkOutput($sformatf("%s_contig", tag), 32'(last_cyc - first_valid + 1), 32'(n));
        end

        // Nothing more may come out, and input must reopen.
        m_tx_axis_trdy = 1'b1;
        stray = 0;
        repeat (3) begin
            @(negedge i_clk);
            if (m_tx_axis_tvalid) stray++;
            @(posedge i_clk); #1;
        end
        checkOutput($sformatf("%s_no_extra", tag), 32'(stray), 32'd0);
        checkOutput($sformatf("%s_rdy_after", tag), 32'(s_tx_axis_trdy), 32'd1);
        checkOutput($sformatf("%s_drop_pulses", tag), 32'(drop_seen - drop0), 32'd0);
        checkOutput($sformatf("%s_lerr_pulses", tag), 32'(lerr_seen - lerr0), 32'(exp_lerr));
    endtask

    task automatic loadBasic();
        stim_q = {8'h00, 8'h35, 8'h00, 8'h44, 8'h00, 8'h00, 8'h00, 8'h00,
                  8'hDE, 8'hAD, 8'hBE, 8'hEF};
    endtask

    task automatic loadRandom(input int n);
        stim_q = {};
        repeat (n) stim_q.push_back(8'($urandom));
    endtask

    // Main sequence of directed and random frames.
    initial begin
        int          stray;
        int          n;
        int          pcts[4];
        logic [15:0] hl;
        logic [15:0] hc;

        pcts = '{30, 50, 80, 100};
        i_reset          = 1'b1;
        s_tx_axis_tdata  = '0;
        s_tx_axis_tvalid = 1'b0;
        s_tx_axis_tlast  = 1'b0;
        s_udp_hdr_tvalid = 1'b0;
        s_udp_length     = '0;
        s_udp_checksum   = '0;
        m_tx_axis_trdy   = 1'b0;

        repeat (3) @(posedge i_clk);
        #1;
        checkOutput("reset_m_valid", 32'(m_tx_axis_tvalid), 32'd0);
        checkOutput("reset_m_last", 32'(m_tx_axis_tlast), 32'd0);
        checkOutput("reset_hdr_trdy", 32'(s_udp_hdr_trdy), 32'd0);
        checkOutput("reset_drop", 32'(o_drop), 32'd0);
        checkOutput("reset_len_err", 32'(o_len_err), 32'd0);
        @(negedge i_clk);
        i_reset = 1'b0;
        @(posedge i_clk); #1;
        checkOutput("reset_s_trdy", 32'(s_tx_axis_trdy), 32'd1);

        // Basic 12-byte frame, then the same frame with a zero checksum.
        loadBasic();
        applyStimulus(16'h000C, 16'h1234, 100, 0, -1, "basic");
        applyStimulus(16'h000C, 16'h0000, 60, 20, -1, "cks0");

        // Header-only frame is still forwarded.
        loadRandom(8);
        applyStimulus(16'h0008, 16'hA5C3, 70, 10, -1, "hdr_only");

        // Largest frame: random back-pressure, then full throughput.
        stim_q = {};
        for (int i = 0; i < MAX_FRAME; i++) stim_q.push_back(8'(i));
        applyStimulus(16'(MAX_FRAME), 16'h5A5A, 50, 0, -1, "max_rnd");
        applyStimulus(16'(MAX_FRAME), 16'hBEEF, 100, 0, -1, "max_full");

        // Oversized frame is dropped; the next frame is unaffected.
        stim_q.push_back(8'hFF);
        applyStimulus(16'(MAX_FRAME + 1), 16'h1111, 50, 0, -1, "ovf");
        loadBasic();
        applyStimulus(16'h000C, 16'h1234, 80, 0, -1, "after_ovf");

        // Runt frame is dropped.
        loadRandom(5);
        applyStimulus(16'h0005, 16'h2222, 100, 0, -1, "runt");

        // Length mismatch: reported but still forwarded with the given value.
        loadRandom(20);
        applyStimulus(16'h0016, 16'h3344, 70, 10, -1, "len_err");

        // Random frames, including runts, mismatches and zero checksums.
        for (int f = 0; f < 10; f++) begin
            n  = int'($urandom_range(1, 64));
            loadRandom(n);
            hl = ($urandom_range(3) == 0) ? 16'($urandom_range(1, 80)) : 16'(n);
            hc = ($urandom_range(3) == 0) ? 16'h0000 : 16'($urandom);
            applyStimulus(hl, hc, pcts[f % 4], 20, -1, $sformatf("rnd%0d", f));
        end

        // Reset while byte 6 of a 12-byte frame sits at the output.
        loadBasic();
        applyStimulus(16'h000C, 16'h1234, 100, 0, 6, "rst");
        checkOutput("rst_pre_valid", 32'(m_tx_axis_tvalid), 32'd1);
        checkOutput("rst_pre_byte6", 32'(m_tx_axis_tdata), 32'h12);
        #2;
        i_reset = 1'b1;
        #1;
        checkOutput("rst_async_valid", 32'(m_tx_axis_tvalid), 32'd0);
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        i_reset = 1'b0;
        @(posedge i_clk); #1;
        stray = 0;
        repeat (20) begin
            @(negedge i_clk);
            if (m_tx_axis_tvalid || !s_tx_axis_trdy) stray++;
            @(posedge i_clk); #1;
        end
        checkOutput("rst_no_resume", 32'(stray), 32'd0);
        loadRandom(16);
        applyStimulus(16'h0010, 16'h0BAD, 60, 10, -1, "post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
